projectile_pool: RTL and testbench
==================================

// Module: projectile_pool
// PURPOSE
//  Multi-slot projectile engine; replaces single-shot projectile logic. Spawns a shot
//  SPAWN_OFFSET px ahead of the character in its facing direction, into the lowest free slot.
//  Advances every live shot 1 px per step tick; retires shots at screen edge or on hit.
//  Sits between character movement (position/direction) and renderer/collision logic.
// PARAMETERS
//  NUM_SLOTS     4   concurrent projectile slots
//  XW            7   x coordinate width
//  YW            6   y coordinate width
//  X_MAX         95  last valid x pixel
//  Y_MAX         63  last valid y pixel
//  SPAWN_OFFSET  20  spawn distance from character origin
//  STEP_DIV      4   clock cycles per 1 px projectile step (>=1)
//  COOLDOWN      10  cycles after an accepted fire before next fire is allowed
// PORTS
//  debouncingclock  in   1              system clock, all logic on rising edge
//  reset            in   1              synchronous, active-high
//  fire             in   1              fire request, level-sensitive
//  chardirection    in   2              00 up, 01 down, 10 left, 11 right
//  xcharacter       in   XW             character x
//  ycharacter       in   YW             character y
//  hit_mask         in   NUM_SLOTS      per-slot hit from collision logic, retires slot
//  active           out  NUM_SLOTS      slot live flags (registered)
//  xproj            out  NUM_SLOTS*XW   packed x, slot i at [i*XW +: XW]
//  yproj            out  NUM_SLOTS*YW   packed y, slot i at [i*YW +: YW]
//  projdir          out  NUM_SLOTS*2    packed direction, slot i at [i*2 +: 2]
//  fire_ack         out  1              1-cycle pulse, fire accepted
//  pool_full        out  1              &active (combinational from registers)
// BEHAVIOUR
//  Reset: active, xproj, yproj, projdir, fire_ack, cooldown counter, prescaler all 0.
//  Cooldown: accept at cycle T loads COOLDOWN; decrements to 0; next accept earliest T+COOLDOWN+1.
//  Accept when fire & cooldown==0 & free slot & spawn in bounds; slot = lowest index with active=0.
//  Spawn pos (computed XW+1/YW+1 bits, no wrap): up (x, y-OFF), down (x, y+OFF),
//    left (x-OFF, y), right (x+OFF, y); out of [0,X_MAX]x[0,Y_MAX] -> rejected.
//  Rejected fire: no slot change, no fire_ack, cooldown not loaded. Held fire retries each cycle.
//  Accept latency: active/pos/dir/fire_ack visible cycle after fire sampled.
//  Free-slot search uses registered active; slot retired in cycle T reusable from T+1.
//  Prescaler counts 0..STEP_DIV-1 and wraps; step tick when count==STEP_DIV-1.
//  On step tick, each active slot moves 1 px in projdir; if at x=0 left, x=X_MAX right,
//    y=0 up or y=Y_MAX down, slot clears active instead (position held).
//  Slot spawned this cycle is not stepped this cycle.
//  hit_mask[i] & active[i] clears slot i; hit wins over step same cycle. Hit on idle slot ignored.
//  Retired slot keeps last x/y/dir; consumers must gate on active.
//  Simultaneous hit on slot k and fire: spawn picks from pre-hit active set.
//  reset mid-flight: all slots cleared next edge, fire ignored that cycle.
//  Input direction/position sampled only on accept; later changes don't affect live shots.
// TESTING
//  1 reset, fire=1 once, char (40,30) dir 11 -> next cycle active=0001, slot0 (60,30), fire_ack=1.
//  2 hold fire with defaults -> accepts at T, T+11, T+22, T+33 into slots 0..3; pool_full=1;
//    further fire no ack until a slot retires.
//  3 shot at x=94 dir right, STEP_DIV=4 -> x=95 after 4 cycles, active clears at next tick.
//  4 char (10,30) dir 10 -> spawn x=-10 rejected, no ack, cooldown stays 0; switch dir 11 -> accepted next cycle.
//  5 slots 0,1 live, hit_mask=0001 on a step tick -> slot0 retires unmoved, slot1 moves 1 px;
//    fire same cycle goes to slot2, following fire after cooldown goes to slot0.
//  6 reset asserted with 3 live shots and fire=1 -> active=0000, fire_ack=0, cooldown=0 next cycle.

Source files
------------

// File: rtl/projectile_pool.sv
// Multi-slot projectile engine: spawns shots ahead of the character into the lowest
// free slot, advances live shots one pixel per step tick, retires them at the edge or on hit.
module projectile_pool #(
  parameter int NUM_SLOTS    = 4,
  parameter int XW           = 7,
  parameter int YW           = 6,
  parameter int X_MAX        = 95,
  parameter int Y_MAX        = 63,
  parameter int SPAWN_OFFSET = 20,
  parameter int STEP_DIV     = 4,
  parameter int COOLDOWN     = 10
) (
  input  logic                    debouncingclock,
  input  logic                    reset,
  input  logic                    fire,
  input  logic [1:0]              chardirection,
  input  logic [XW-1:0]           xcharacter,
  input  logic [YW-1:0]           ycharacter,
  input  logic [NUM_SLOTS-1:0]    hit_mask,
  output logic [NUM_SLOTS-1:0]    active,
  output logic [NUM_SLOTS*XW-1:0] xproj,
  output logic [NUM_SLOTS*YW-1:0] yproj,
  output logic [NUM_SLOTS*2-1:0]  projdir,
  output logic                    fire_ack,
  output logic                    pool_full
);

  localparam int PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [PW-1:0]  pre;
  logic [CW-1:0]  cd;
  logic           tick;
  logic [XW:0]    spawn_x;
  logic [YW:0]    spawn_y;
  logic           spawn_ok;
  logic           free_found;
  logic [SW-1:0]  free_idx;
  logic           accept;

  assign tick      = (pre == PW'(STEP_DIV - 1));
  assign pool_full = &active;

  // One extra bit keeps the spawn point from wrapping; a negative result reads as a
  // large unsigned value and fails the upper-bound compare.
  always_comb begin
    spawn_x = {1'b0, xcharacter};
    spawn_y = {1'b0, ycharacter};
    case (chardirection)
      DIR_UP:    spawn_y = {1'b0, ycharacter} - YW1'(SPAWN_OFFSET);
      DIR_DOWN:  spawn_y = {1'b0, ycharacter} + YW1'(SPAWN_OFFSET);
      DIR_LEFT:  spawn_x = {1'b0, xcharacter} - XW1'(SPAWN_OFFSET);
      default:   spawn_x = {1'b0, xcharacter} + XW1'(SPAWN_OFFSET);
    endcase
    spawn_ok = (spawn_x <= XW1'(X_MAX)) && (spawn_y <= YW1'(Y_MAX));
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  assign accept = fire && (cd == '0) && free_found && spawn_ok;

  always_ff @(posedge debouncingclock) begin
    if (reset) begin
      active   <= '0;
      xproj    <= '0;
      yproj    <= '0;
      projdir  <= '0;
      fire_ack <= 1'b0;
      cd       <= '0;
      pre      <= '0;
    end else begin
      fire_ack <= accept;
      pre      <= tick ? '0 : pre + 1'b1;
      if (accept)
        cd <= CW'(COOLDOWN);
      else if (cd != '0)
        cd <= cd - 1'b1;

      // A freshly spawned slot was idle, so it never also sees a hit or a step.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (accept && (free_idx == SW'(i))) begin
          active[i]          <= 1'b1;
          xproj[i*XW +: XW]  <= spawn_x[XW-1:0];
          yproj[i*YW +: YW]  <= spawn_y[YW-1:0];
          projdir[i*2 +: 2]  <= chardirection;
        end else if (active[i] && hit_mask[i]) begin
          active[i] <= 1'b0;
        end else if (active[i] && tick) begin
          case (projdir[i*2 +: 2])
            DIR_UP:
              if (yproj[i*YW +: YW] == '0) active[i] <= 1'b0;
              else yproj[i*YW +: YW] <= yproj[i*YW +: YW] - 1'b1;
            DIR_DOWN:
              if (yproj[i*YW +: YW] == YW'(Y_MAX)) active[i] <= 1'b0;
              else yproj[i*YW +: YW] <= yproj[i*YW +: YW] + 1'b1;
            DIR_LEFT:
              if (xproj[i*XW +: XW] == '0) active[i] <= 1'b0;
              else xproj[i*XW +: XW] <= xproj[i*XW +: XW] - 1'b1;
            default:
              if (xproj[i*XW +: XW] == XW'(X_MAX)) active[i] <= 1'b0;
              else xproj[i*XW +: XW] <= xproj[i*XW +: XW] + 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: per-cycle reference model feeding a scoreboard queue,
// a spawn vector table, and hand-written sequences for the multi-cycle corners.
module tb_projectile_pool;

  localparam int NS   = 4;
  localparam int XW   = 7;
  localparam int YW   = 6;
  localparam int XMAX = 95;
  localparam int YMAX = 63;
  localparam int OFF  = 20;
  localparam int SDIV = 4;
  localparam int CDN  = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           fire = 1'b0;
  logic [1:0]     chardirection = 2'b11;
  logic [XW-1:0]  xcharacter = '0;
  logic [YW-1:0]  ycharacter = '0;
  logic [NS-1:0]  hit_mask = '0;
  logic [NS-1:0]  active;
  logic [NS*XW-1:0] xproj;
  logic [NS*YW-1:0] yproj;
  logic [NS*2-1:0]  projdir;
  logic           fire_ack;
  logic           pool_full;

  projectile_pool dut (
    .debouncingclock(clk), .reset(reset), .fire(fire), .chardirection(chardirection),
    .xcharacter(xcharacter), .ycharacter(ycharacter), .hit_mask(hit_mask),
    .active(active), .xproj(xproj), .yproj(yproj), .projdir(projdir),
    .fire_ack(fire_ack), .pool_full(pool_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0]    act;
    logic [NS*XW-1:0] x;
    logic [NS*YW-1:0] y;
    logic [NS*2-1:0]  d;
    logic             ack;
    logic             full;
  } exp_t;

  typedef struct {
    logic [1:0] dir;
    int x;
    int y;
    bit ok;
    int ex;
    int ey;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit         ma[NS];
  int         mx[NS];
  int         my[NS];
  logic [1:0] md[NS];
  int         mcd = 0;
  int         mpre = 0;
  bit         mack = 0;

  task automatic model_edge();
    exp_t e;
    int sx, sy, fi;
    bit tk, acc;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        ma[i] = 0; mx[i] = 0; my[i] = 0; md[i] = 2'b00;
      end
      mcd = 0; mpre = 0; mack = 0;
    end else begin
      tk = (mpre == SDIV - 1);
      fi = -1;
      for (int i = NS - 1; i >= 0; i--) if (!ma[i]) fi = i;
      sx = int'(xcharacter);
      sy = int'(ycharacter);
      case (chardirection)
        2'b00: sy = sy - OFF;
        2'b01: sy = sy + OFF;
        2'b10: sx = sx - OFF;
        default: sx = sx + OFF;
      endcase
      acc = fire && (mcd == 0) && (fi >= 0) && sx >= 0 && sx <= XMAX && sy >= 0 && sy <= YMAX;
      for (int i = 0; i < NS; i++) begin
        if (ma[i]) begin
          if (hit_mask[i]) ma[i] = 0;
          else if (tk) begin
            case (md[i])
              2'b00: if (my[i] == 0) ma[i] = 0; else my[i] = my[i] - 1;
              2'b01: if (my[i] == YMAX) ma[i] = 0; else my[i] = my[i] + 1;
              2'b10: if (mx[i] == 0) ma[i] = 0; else mx[i] = mx[i] - 1;
              default: if (mx[i] == XMAX) ma[i] = 0; else mx[i] = mx[i] + 1;
            endcase
          end
        end
      end
      if (acc) begin
        ma[fi] = 1; mx[fi] = sx; my[fi] = sy; md[fi] = chardirection;
      end
      mcd  = acc ? CDN : ((mcd > 0) ? mcd - 1 : 0);
      mpre = tk ? 0 : mpre + 1;
      mack = acc;
    end
    for (int i = 0; i < NS; i++) begin
      e.act[i]         = ma[i];
      e.x[i*XW +: XW]  = XW'(mx[i]);
      e.y[i*YW +: YW]  = YW'(my[i]);
      e.d[i*2 +: 2]    = md[i];
    end
    e.ack  = mack;
    e.full = &e.act;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty cyc=%0d", cyc);
    end else begin
      e = sb.pop_front();
      if ({active, xproj, yproj, projdir, fire_ack, pool_full} !==
          {e.act, e.x, e.y, e.d, e.ack, e.full}) begin
        n_bad++;
        $display("FAIL scoreboard cyc=%0d got act=%b x=%h y=%h d=%h ack=%b full=%b want act=%b x=%h y=%h d=%h ack=%b full=%b",
                 cyc, active, xproj, yproj, projdir, fire_ack, pool_full,
                 e.act, e.x, e.y, e.d, e.ack, e.full);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; fire = 1'b0; hit_mask = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_char(input int x, input int y, input logic [1:0] d);
    xcharacter = XW'(x); ycharacter = YW'(y); chardirection = d;
  endtask

  initial begin
    int acks[$];
    int n, guard;

    vt[0] = '{2'b11, 40, 30, 1'b1, 60, 30};
    vt[1] = '{2'b10, 10, 30, 1'b0, 0, 0};
    vt[2] = '{2'b10, 20, 30, 1'b1, 0, 30};
    vt[3] = '{2'b11, 75,  5, 1'b1, 95, 5};
    vt[4] = '{2'b11, 76,  5, 1'b0, 0, 0};
    vt[5] = '{2'b00, 50, 20, 1'b1, 50, 0};
    vt[6] = '{2'b00, 50, 19, 1'b0, 0, 0};
    vt[7] = '{2'b01,  5, 43, 1'b1, 5, 63};
    vt[8] = '{2'b01,  5, 44, 1'b0, 0, 0};
    vt[9] = '{2'b01,  0,  0, 1'b1, 0, 20};

    do_reset();
    chk("reset_active", int'(active), 0);
    chk("reset_ack", int'(fire_ack), 0);
    chk("reset_xproj", int'(xproj), 0);

    // Spawn placement and bounds
    for (int k = 0; k < 10; k++) begin
      do_reset();
      set_char(vt[k].x, vt[k].y, vt[k].dir);
      fire = 1'b1;
      step();
      fire = 1'b0;
      chk($sformatf("spawn%0d_ack", k), int'(fire_ack), int'(vt[k].ok));
      chk($sformatf("spawn%0d_active", k), int'(active), int'(vt[k].ok));
      if (vt[k].ok) begin
        chk($sformatf("spawn%0d_x", k), int'(xproj[XW-1:0]), vt[k].ex);
        chk($sformatf("spawn%0d_y", k), int'(yproj[YW-1:0]), vt[k].ey);
        chk($sformatf("spawn%0d_dir", k), int'(projdir[1:0]), int'(vt[k].dir));
      end
    end

    // Held fire fills the pool at cooldown spacing
    do_reset();
    set_char(40, 30, 2'b11);
    fire = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (fire_ack) acks.push_back(k);
    end
    chk("hold_ack_count", acks.size(), 4);
    for (int k = 1; k < acks.size(); k++) chk("hold_ack_gap", acks[k] - acks[k-1], CDN + 1);
    chk("hold_active", int'(active), 15);
    chk("hold_pool_full", int'(pool_full), 1);
    hit_mask = 4'b0100;
    step();
    chk("full_hit_same_cycle_ack", int'(fire_ack), 0);
    chk("full_hit_same_cycle_active", int'(active), 4'b1011);
    hit_mask = '0;
    step();
    chk("reuse_next_cycle_ack", int'(fire_ack), 1);
    chk("reuse_next_cycle_active", int'(active), 15);
    fire = 1'b0;

    // Right-edge retirement
    do_reset();
    set_char(74, 30, 2'b11);
    fire = 1'b1;
    step();
    fire = 1'b0;
    chk("edge_spawn_x", int'(xproj[XW-1:0]), 94);
    guard = 0;
    while (xproj[XW-1:0] != 7'd95 && guard < 20) begin step(); guard++; end
    chk("edge_reach_95", int'(xproj[XW-1:0]), 95);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(); n++;
      if (!active[0]) break;
    end
    chk("edge_retire_cycles", n, SDIV);
    chk("edge_retire_active", int'(active[0]), 0);
    chk("edge_hold_x", int'(xproj[XW-1:0]), 95);

    // Rejected fire leaves cooldown untouched
    do_reset();
    set_char(10, 30, 2'b10);
    fire = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reject_ack", int'(fire_ack), 0);
    end
    chardirection = 2'b11;
    step();
    fire = 1'b0;
    chk("retry_ack", int'(fire_ack), 1);
    chk("retry_x", int'(xproj[XW-1:0]), 30);

    // Hit on a step tick plus simultaneous fire
    do_reset();
    set_char(40, 30, 2'b11);
    fire = 1'b1;
    step();
    fire = 1'b0;
    for (int k = 0; k < CDN; k++) step();
    fire = 1'b1;
    step();
    fire = 1'b0;
    chk("two_live_active", int'(active), 4'b0011);
    for (int k = 0; k < CDN; k++) step();
    guard = 0;
    while (mpre != SDIV - 1 && guard < 8) begin step(); guard++; end
    hit_mask = 4'b0001;
    fire = 1'b1;
    step();
    hit_mask = '0;
    chk("hit_fire_ack", int'(fire_ack), 1);
    chk("hit_fire_active", int'(active), 4'b0110);
    chk("hit_fire_slot2_x", int'(xproj[2*XW +: XW]), 60);
    for (int k = 0; k < 15; k++) begin
      step();
      if (fire_ack) break;
    end
    fire = 1'b0;
    chk("refill_slot0_active", int'(active), 4'b0111);
    chk("refill_slot0_x", int'(xproj[XW-1:0]), 60);

    // Reset mid-flight with fire held
    do_reset();
    set_char(40, 30, 2'b11);
    fire = 1'b1;
    for (int k = 0; k < 2*(CDN+1) + 1; k++) step();
    chk("three_live_active", int'(active), 4'b0111);
    reset = 1'b1;
    step();
    chk("midreset_active", int'(active), 0);
    chk("midreset_ack", int'(fire_ack), 0);
    reset = 1'b0;
    step();
    chk("post_reset_ack", int'(fire_ack), 1);
    chk("post_reset_active", int'(active), 1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(99) == 0);
      fire = $urandom_range(1);
      set_char($urandom_range(XMAX), $urandom_range(YMAX), 2'($urandom_range(3)));
      for (int i = 0; i < NS; i++) hit_mask[i] = ($urandom_range(7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
